// File: rtl/single_clock_fifo.sv
// Single-clock FIFO of 2**ASIZE words with full/empty and almost-full/almost-empty flags.
// Defining SINGLE_CLOCK_FIFO_ERR_FLAGS_EN adds sticky overflow_o/underflow_o outputs.
module single_clock_fifo #(
    parameter int    DSIZE       = 8,
    parameter int    ASIZE       = 4,
    parameter int    AWFULLSIZE  = 1,
    parameter int    AREMPTYSIZE = 1,
    parameter string FALLTHROUGH = "TRUE"
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             awfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             arempty
`ifdef SINGLE_CLOCK_FIFO_ERR_FLAGS_EN
    ,
    output logic             overflow_o,
    output logic             underflow_o
`endif
);
    localparam int DEPTH = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_C = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AWF_C   = (ASIZE+1)'(DEPTH - AWFULLSIZE);
    localparam logic [ASIZE:0] ARE_C   = (ASIZE+1)'(AREMPTYSIZE);

    if (ASIZE < 1) begin : g_chk_asize
        $error("single_clock_fifo: ASIZE must be >= 1");
    end
    if (AWFULLSIZE < 1 || AWFULLSIZE > DEPTH - 1) begin : g_chk_awfull
        $error("single_clock_fifo: AWFULLSIZE out of range");
    end
    if (AREMPTYSIZE < 1 || AREMPTYSIZE > DEPTH - 1) begin : g_chk_arempty
        $error("single_clock_fifo: AREMPTYSIZE out of range");
    end
    if (FALLTHROUGH != "TRUE" && FALLTHROUGH != "FALSE") begin : g_chk_ft
        $error("single_clock_fifo: FALLTHROUGH must be \"TRUE\" or \"FALSE\"");
    end

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [ASIZE-1:0] wptr_q, wptr_d;
    logic [ASIZE-1:0] rptr_q, rptr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic             we, re;

    // Handshake: winc/rinc are requests; a request is accepted at the edge only if
    // wfull/rempty was low before that edge, and a rejected request changes nothing.
    assign wfull   = (count_q == DEPTH_C);
    assign awfull  = (count_q >= AWF_C);
    assign rempty  = (count_q == '0);
    assign arempty = (count_q <= ARE_C);
    assign we      = winc & ~wfull;
    assign re      = rinc & ~rempty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (we) wptr_d = wptr_q + 1'b1;
        if (re) rptr_d = rptr_q + 1'b1;
        case ({we, re})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset; only the pointers define valid contents.
    always_ff @(posedge clk_i) begin
        if (!reset_i && we) mem_q[wptr_q] <= wdata;
    end

    if (FALLTHROUGH == "TRUE") begin : g_fallthrough
        assign rdata = rempty ? '0 : mem_q[rptr_q];
    end else begin : g_registered
        logic [DSIZE-1:0] rdata_q;
        always_ff @(posedge clk_i) begin
            if (reset_i)  rdata_q <= '0;
            else if (re)  rdata_q <= mem_q[rptr_q];
        end
        assign rdata = rdata_q;
    end

`ifdef SINGLE_CLOCK_FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (winc && wfull)  overflow_q  <= 1'b1;
            if (rinc && rempty) underflow_q <= 1'b1;
        end
    end
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`endif
endmodule

// File: tb/tb_single_clock_fifo.sv
// Bench for single_clock_fifo: a fall-through instance driven by a vector table and
// corner-case sequences, plus a registered-read instance for the latency cases.
module tb_single_clock_fifo;
    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       ft_winc, ft_rinc, rg_winc, rg_rinc;
    logic [7:0] ft_wdata, rg_wdata, ft_rdata, rg_rdata;
    logic       ft_wfull, ft_awfull, ft_rempty, ft_arempty;
    logic       rg_wfull, rg_awfull, rg_rempty, rg_arempty;
`ifdef SINGLE_CLOCK_FIFO_ERR_FLAGS_EN
    logic       ft_ovf, ft_unf, rg_ovf, rg_unf;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    single_clock_fifo #(.DSIZE(8), .ASIZE(4), .AWFULLSIZE(1), .AREMPTYSIZE(1), .FALLTHROUGH("TRUE")) dut_ft (
        .clk_i(clk_i), .reset_i(reset_i),
        .winc(ft_winc), .wdata(ft_wdata), .wfull(ft_wfull), .awfull(ft_awfull),
        .rinc(ft_rinc), .rdata(ft_rdata), .rempty(ft_rempty), .arempty(ft_arempty)
`ifdef SINGLE_CLOCK_FIFO_ERR_FLAGS_EN
        , .overflow_o(ft_ovf), .underflow_o(ft_unf)
`endif
    );

    single_clock_fifo #(.DSIZE(8), .ASIZE(4), .AWFULLSIZE(1), .AREMPTYSIZE(1), .FALLTHROUGH("FALSE")) dut_rg (
        .clk_i(clk_i), .reset_i(reset_i),
        .winc(rg_winc), .wdata(rg_wdata), .wfull(rg_wfull), .awfull(rg_awfull),
        .rinc(rg_rinc), .rdata(rg_rdata), .rempty(rg_rempty), .arempty(rg_arempty)
`ifdef SINGLE_CLOCK_FIFO_ERR_FLAGS_EN
        , .overflow_o(rg_ovf), .underflow_o(rg_unf)
`endif
    );

    typedef struct {
        logic       winc;
        logic [7:0] wdata;
        logic       rinc;
        logic       rempty;
        logic       arempty;
        logic       wfull;
        logic       awfull;
        logic [7:0] rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ft_drive(input logic w, input logic [7:0] d, input logic r);
        ft_winc  = w;
        ft_wdata = d;
        ft_rinc  = r;
    endtask

    initial begin
        // Expected flags decode count: arempty for count<=1, awfull for count>=15.
        vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
        vecs[7]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
        vecs[8]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33};
        vecs[10] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

        reset_i = 1'b1;
        ft_drive(1'b0, 8'h00, 1'b0);
        rg_winc = 1'b0; rg_wdata = 8'h00; rg_rinc = 1'b0;
        tick();
        tick();
        reset_i = 1'b0;
        check("rg reset rdata", 32'(rg_rdata), 32'h00);
        check("rg reset rempty", 32'(rg_rempty), 32'h1);
`ifdef SINGLE_CLOCK_FIFO_ERR_FLAGS_EN
        check("ft reset overflow", 32'(ft_ovf), 32'h0);
        check("ft reset underflow", 32'(ft_unf), 32'h0);
`endif

        for (int i = 0; i < 14; i++) begin
            ft_drive(vecs[i].winc, vecs[i].wdata, vecs[i].rinc);
            tick();
            check($sformatf("vec%0d rempty", i),  32'(ft_rempty),  32'(vecs[i].rempty));
            check($sformatf("vec%0d arempty", i), 32'(ft_arempty), 32'(vecs[i].arempty));
            check($sformatf("vec%0d wfull", i),   32'(ft_wfull),   32'(vecs[i].wfull));
            check($sformatf("vec%0d awfull", i),  32'(ft_awfull),  32'(vecs[i].awfull));
            check($sformatf("vec%0d rdata", i),   32'(ft_rdata),   32'(vecs[i].rdata));
        end
        ft_drive(1'b0, 8'h00, 1'b0);
`ifdef SINGLE_CLOCK_FIFO_ERR_FLAGS_EN
        check("ft underflow sticky", 32'(ft_unf), 32'h1);
        check("ft overflow clear", 32'(ft_ovf), 32'h0);
`endif

        // Fill to full, attempt one overflow write, then drain with rinc held.
        for (int i = 0; i < 16; i++) begin
            ft_drive(1'b1, 8'(i), 1'b0);
            tick();
            if (i == 14) begin
                check("fill15 awfull", 32'(ft_awfull), 32'h1);
                check("fill15 wfull", 32'(ft_wfull), 32'h0);
            end
        end
        check("fill16 wfull", 32'(ft_wfull), 32'h1);
        ft_drive(1'b1, 8'hFF, 1'b0);
        tick();
        ft_drive(1'b0, 8'h00, 1'b0);
        check("overflow wfull", 32'(ft_wfull), 32'h1);
        check("overflow head", 32'(ft_rdata), 32'h00);
`ifdef SINGLE_CLOCK_FIFO_ERR_FLAGS_EN
        check("ft overflow sticky", 32'(ft_ovf), 32'h1);
`endif
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d rdata", i), 32'(ft_rdata), 32'(i));
            ft_drive(1'b0, 8'h00, 1'b1);
            tick();
        end
        ft_drive(1'b0, 8'h00, 1'b0);
        check("drain rempty", 32'(ft_rempty), 32'h1);
        check("drain rdata", 32'(ft_rdata), 32'h00);

        // Wrap: 10 writes and 10 reads move pointers to 10, then overlap across the wrap.
        for (int i = 0; i < 10; i++) begin
            ft_drive(1'b1, 8'h60 + 8'(i), 1'b0);
            exp_q.push_back(8'h60 + 8'(i));
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            check($sformatf("wrapA%0d rdata", i), 32'(ft_rdata), 32'(exp_q.pop_front()));
            ft_drive(1'b0, 8'h00, 1'b1);
            tick();
        end
        check("wrapA rempty", 32'(ft_rempty), 32'h1);
        for (int i = 0; i < 3; i++) begin
            ft_drive(1'b1, 8'h80 + 8'(i), 1'b0);
            exp_q.push_back(8'h80 + 8'(i));
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            check($sformatf("wrapB%0d rdata", i), 32'(ft_rdata), 32'(exp_q.pop_front()));
            ft_drive(1'b1, 8'h90 + 8'(i), 1'b1);
            exp_q.push_back(8'h90 + 8'(i));
            tick();
            check($sformatf("wrapB%0d arempty", i), 32'(ft_arempty), 32'h0);
            check($sformatf("wrapB%0d rempty", i), 32'(ft_rempty), 32'h0);
        end
        while (exp_q.size() > 0) begin
            check("wrapC rdata", 32'(ft_rdata), 32'(exp_q.pop_front()));
            ft_drive(1'b0, 8'h00, 1'b1);
            tick();
        end
        ft_drive(1'b0, 8'h00, 1'b0);
        check("wrapC rempty", 32'(ft_rempty), 32'h1);

        // Registered read port: one-cycle latency and hold on empty read.
        rg_winc = 1'b1; rg_wdata = 8'h3C;
        tick();
        rg_winc = 1'b0;
        check("rg write rempty", 32'(rg_rempty), 32'h0);
        check("rg rdata before rinc", 32'(rg_rdata), 32'h00);
        rg_rinc = 1'b1;
        tick();
        rg_rinc = 1'b0;
        check("rg rdata after rinc", 32'(rg_rdata), 32'h3C);
        check("rg rempty after rinc", 32'(rg_rempty), 32'h1);
        rg_rinc = 1'b1;
        tick();
        rg_rinc = 1'b0;
        check("rg rdata hold", 32'(rg_rdata), 32'h3C);
`ifdef SINGLE_CLOCK_FIFO_ERR_FLAGS_EN
        check("rg underflow sticky", 32'(rg_unf), 32'h1);
`endif

        // Mid-stream reset with 5 words stored.
        for (int i = 0; i < 5; i++) begin
            ft_drive(1'b1, 8'hB0 + 8'(i), 1'b0);
            tick();
        end
        ft_drive(1'b0, 8'h00, 1'b0);
        check("pre-reset arempty", 32'(ft_arempty), 32'h0);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("mid reset rempty", 32'(ft_rempty), 32'h1);
        check("mid reset arempty", 32'(ft_arempty), 32'h1);
        check("mid reset rdata", 32'(ft_rdata), 32'h00);
        check("mid reset rg rdata", 32'(rg_rdata), 32'h00);
`ifdef SINGLE_CLOCK_FIFO_ERR_FLAGS_EN
        check("mid reset overflow", 32'(ft_ovf), 32'h0);
        check("mid reset underflow", 32'(rg_unf), 32'h0);
`endif
        ft_drive(1'b1, 8'hC7, 1'b0);
        tick();
        check("post reset rdata", 32'(ft_rdata), 32'hC7);
        check("post reset arempty", 32'(ft_arempty), 32'h1);
        ft_drive(1'b0, 8'h00, 1'b1);
        tick();
        ft_drive(1'b0, 8'h00, 1'b0);
        check("post reset rempty", 32'(ft_rempty), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
